// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per clock.
// diff/borrow are registered and only change when an operation completes.
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit, br_nxt, last_bit;

  assign d_bit    = sh_a[0] ^ sh_b[0] ^ br;
  assign br_nxt   = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

  // Datapath: the final SUB edge loads diff/borrow directly so they are valid on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            sh_b <= b;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
          end
        end
        SUB: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= {d_bit, res[WIDTH-1:1]};
          br   <= br_nxt;
          if (!last_bit) cnt <= cnt + CW'(1);
          if (last_bit) begin
            diff   <= {d_bit, res[WIDTH-1:1]};
            borrow <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor with an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_exp = '0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input int ia, input int ib);
    int d;
    d = (ia - ib + MOD) % MOD;
    return {(ib > ia) ? 1'b1 : 1'b0, WIDTH'(d)};
  endfunction

  // One operation: start pulsed for one cycle; optionally a second start mid-operation.
  task automatic run_op(input int ia, input int ib, input bit inject);
    int n, bc, extra;
    bit seen;
    logic [WIDTH:0] e;
    exp_q.push_back(model(ia, ib));
    @(posedge clk); #1;
    start = 1'b1; a = WIDTH'(ia); b = WIDTH'(ib);
    n = 0; bc = 0; seen = 0;
    @(posedge clk); n++; #1;
    start = 1'b0;
    a = WIDTH'($urandom_range(0, MOD - 1));
    b = WIDTH'($urandom_range(0, MOD - 1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin seen = 1; break; end
      check("hold", {borrow, diff}, last_exp);
      @(posedge clk); n++; #1;
      start = (inject && n == 2);
      if (inject && n == 2) begin a = WIDTH'(1); b = WIDTH'(7); end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (seen) begin
      e = exp_q.pop_front();
      check("latency", n, WIDTH + 1);
      check("busy_cycles", bc, WIDTH + 1);
      check("diff", diff, e[WIDTH-1:0]);
      check("borrow", borrow, e[WIDTH]);
      last_exp = e;
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("idle_busy", busy, 0);
    if (inject) begin
      extra = 0;
      for (int k = 0; k < WIDTH + 3; k++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("no_second_done", extra, 0);
      check("hold_after_ignore", {borrow, diff}, last_exp);
    end
  endtask

  initial begin
    int cnt, last_i, gap_bad;
    int ra, rb;
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // directed vectors
    run_op(7, 1, 0);
    run_op(5, 4, 0);
    run_op(3, 5, 0);
    run_op(0, 0, 0);
    run_op(0, 7, 0);

    // start during SUB is ignored
    run_op(6, 2, 1);

    // reset aborts an operation
    @(posedge clk); #1;
    start = 1'b1; a = WIDTH'(2); b = WIDTH'(3);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    last_exp = '0;
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    cnt = 0;
    for (int k = 0; k < WIDTH + 3; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_op(2, 3, 0);

    // randomized operations
    for (int t = 0; t < 16; t++) begin
      ra = $urandom_range(0, MOD - 1);
      rb = $urandom_range(0, MOD - 1);
      run_op(ra, rb, 0);
    end

    // start held high: one result every WIDTH+2 cycles
    cnt = 0; last_i = -1; gap_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = (i < 12);
      a = WIDTH'(4); b = WIDTH'(4);
      @(negedge clk);
      if (done) begin
        cnt++;
        check("cont_diff", diff, 0);
        check("cont_borrow", borrow, 0);
        if (last_i >= 0 && (i - last_i) != WIDTH + 2) gap_bad++;
        last_i = i;
      end
    end
    start = 1'b0;
    check("cont_count", cnt, 11 / (WIDTH + 2) + 1);
    check("cont_spacing", gap_bad, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
